// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding,
// frame-format limits and baud divisor rounding.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Nearest-integer divisor so the bit period error stays below half a clock.
  function automatic int calc_clks_per_bit(int clk_hz, int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Restartable bit-period counter; tick marks the last clock of each bit.
// Shared between the UART transmitter and receiver.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-Stream byte sink that serialises each accepted word as a UART frame.
// Ready is held low for the whole frame; tx comes straight from a flop.
module axis_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 tx,
  output logic                 busy
);

  localparam int CPB = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (CPB < 2) begin : g_bad_cpb
    $error("axis_uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_db
    $error("axis_uart_tx: DATA_BITS out of range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_sb
    $error("axis_uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_tx_state_e state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [3:0] bit_q, bit_d;
  logic par_q, par_d;
  logic tx_q, tx_d;
  logic busy_q, busy_d;
  logic rdy_q, rdy_d;
  logic transfer, tick, baud_en;

  assign transfer = s_valid && rdy_q;
  assign baud_en  = (state_q != IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CPB)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(transfer),
    .enable (baud_en),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (transfer) begin
          state_d = START;
          sh_d    = s_data;
          par_d   = (^s_data) ^ (PARITY_ODD != 0);
          bit_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          rdy_d   = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == LAST_DATA) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_q == LAST_STOP) begin
            state_d = IDLE;
            bit_d   = '0;
            busy_d  = 1'b0;
            rdy_d   = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign s_ready = rdy_q;

endmodule
